// File: rtl/m65_bus_wait_gen_if.sv
// ============================================================================
// Module   : m65_bus_wait_gen_if
// Brief    : CPU bus-cycle handshake bundle between the CPU/speed-control side
//            and the wait-state generator.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface m65_bus_wait_gen_if;
    logic        cpu_req;
    logic [19:0] cpu_addr;
    logic        cpu_write;
    logic        cpu_ready;
    logic        bus_ready;
    logic        bus_busy;

    modport master (
        output cpu_req,
        output cpu_addr,
        output cpu_write,
        output cpu_ready,
        input  bus_ready,
        input  bus_busy
    );

    modport slave (
        input  cpu_req,
        input  cpu_addr,
        input  cpu_write,
        input  cpu_ready,
        output bus_ready,
        output bus_busy
    );
endinterface

`default_nettype wire

// File: rtl/m65_bus_wait_gen.sv
// ============================================================================
// Module   : m65_bus_wait_gen
// Brief    : Region-decoded wait-state generator producing bus_ready; holds
//            completion until the paced cpu_ready consumes it.
//            Optional wait statistics: define M65_BUS_WAIT_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module m65_bus_wait_gen #(
    parameter int FASTRAM_WAITS = 0,
    parameter int ROM_WAITS     = 2,
    parameter int EXT_WAITS     = 6
) (
    input  wire logic               clk,
    input  wire logic               reset,
    m65_bus_wait_gen_if.slave       bus,
    input  wire logic [3:0]         io_waits,
    input  wire logic               hypervisor_mode,
    input  wire logic               stat_clear,
    output logic      [1:0]         cur_region,
    output logic      [31:0]        wait_cycles
);

    localparam logic [3:0] c_fast_waits = 4'(FASTRAM_WAITS);
    localparam logic [3:0] c_rom_waits  = 4'(ROM_WAITS);
    localparam logic [3:0] c_ext_waits  = 4'(EXT_WAITS);

    localparam logic [1:0] c_reg_fast = 2'd0;
    localparam logic [1:0] c_reg_io   = 2'd1;
    localparam logic [1:0] c_reg_rom  = 2'd2;
    localparam logic [1:0] c_reg_ext  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic [1:0]  r_region;
    logic [1:0]  w_region;
    logic [3:0]  w_waits;
    logic        w_accept;
    logic        w_bus_ready;
    logic        w_addr_unused;

    assign w_addr_unused = ^bus.cpu_addr[11:0];

    // Region decode; IO is checked first so it wins over everything else.
    always_comb begin
        w_region = c_reg_fast;
        if (bus.cpu_addr[19:12] == 8'h0D)
            w_region = c_reg_io;
        else if (bus.cpu_addr[19:17] == 3'b001)
            w_region = c_reg_rom;
        else if (bus.cpu_addr[19:18] == 2'b01)
            w_region = c_reg_ext;
    end

    always_comb begin
        w_waits = c_fast_waits;
        case (w_region)
            c_reg_io:  w_waits = io_waits;
            c_reg_rom: w_waits = (!bus.cpu_write && !hypervisor_mode) ? c_rom_waits
                                                                      : c_fast_waits;
            c_reg_ext: w_waits = c_ext_waits;
            default:   w_waits = c_fast_waits;
        endcase
    end

    assign w_accept = bus.cpu_req && (r_state == ST_IDLE) && !reset;

    // Kept independent of cpu_ready so the speed controller may gate it back in.
    always_comb begin
        w_bus_ready = 1'b1;
        if (!reset) begin
            if (r_state == ST_IDLE && bus.cpu_req && w_waits != 4'd0)
                w_bus_ready = 1'b0;
            else if (r_state == ST_WAIT && r_cnt != 4'd0)
                w_bus_ready = 1'b0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    if (w_waits == 4'd0) begin
                        if (!bus.cpu_ready)
                            w_state_next = ST_DONE;
                    end else begin
                        w_cnt_next   = w_waits - 4'd1;
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt != 4'd0)
                    w_cnt_next = r_cnt - 4'd1;
                else if (bus.cpu_ready)
                    w_state_next = ST_IDLE;
                else
                    w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (bus.cpu_ready)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_region <= c_reg_fast;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept)
                r_region <= w_region;
        end
    end

    assign bus.bus_ready = w_bus_ready;
    assign bus.bus_busy  = (r_state != ST_IDLE);
    assign cur_region    = r_region;

`ifdef M65_BUS_WAIT_STATS_EN
    logic [31:0] r_wait_cycles;

    always_ff @(posedge clk) begin
        if (reset)
            r_wait_cycles <= 32'd0;
        else if (stat_clear)
            r_wait_cycles <= 32'd0;
        else if (!w_bus_ready && r_wait_cycles != 32'hFFFF_FFFF)
            r_wait_cycles <= r_wait_cycles + 32'd1;
    end

    assign wait_cycles = r_wait_cycles;
`else
    logic w_stat_unused;
    assign w_stat_unused = stat_clear;
    assign wait_cycles   = 32'd0;
`endif

endmodule

`default_nettype wire
